// File: rtl/xbar_pkg.sv
// Shared types and sizing for the crossbar slave-side write path.
package xbar_pkg;
    localparam int XB_MASTERS  = 2;
    localparam int XB_SLAVES   = 2;
    localparam int XB_ID_WIDTH = 4;
    localparam int MW = (XB_MASTERS > 1) ? $clog2(XB_MASTERS) : 1;
    localparam int SW = (XB_SLAVES > 1) ? $clog2(XB_SLAVES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [XB_ID_WIDTH-1:0] id;
        logic [1:0]             resp;
        logic [MW-1:0]          dest;
    } b_entry_t;
endpackage

// File: rtl/xbar_slave_write_port_b_ret_buf.sv
// Two-entry FIFO holding B responses until the owning master's backward arbiter takes them.
module b_ret_buf
    import xbar_pkg::*;
(
    input  logic     ACLK,
    input  logic     ARESETn,
    input  logic     push_i,
    input  b_entry_t din_i,
    input  logic     pop_i,
    output b_entry_t dout_o,
    output logic     full_o,
    output logic     empty_o
);
    b_entry_t   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    // Full is registered, so a pop at full never makes room for a same-cycle push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/xbar_slave_write_port.sv
// Slave-side write port: round-robin AW arbitration, W locked to the AW owner until WLAST,
// per-ID owner tracking and a small B return buffer.
module xbar_slave_write_port
    import xbar_pkg::*;
#(
    parameter int ID_WIDTH          = XB_ID_WIDTH,
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4,
    parameter int SIZE_WIDTH        = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int STRB_WIDTH        = 4,
    parameter int masters           = XB_MASTERS,
    parameter int slaves            = XB_SLAVES,
    parameter int i_am_slave_number = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  master_write_addr_fifo_empty  [0:masters-1],
    input  logic [SW-1:0]         write_addr_forward_dest_slave [0:masters-1],
    input  logic [ID_WIDTH-1:0]   AWID                          [0:masters-1],
    input  logic [ADDR_WIDTH-1:0] AWADDR                        [0:masters-1],
    input  logic [LEN_WIDTH-1:0]  AWLEN                         [0:masters-1],
    input  logic [SIZE_WIDTH-1:0] AWSIZE                        [0:masters-1],
    input  logic [1:0]            AWBURST                       [0:masters-1],
    output logic                  slave_write_addr_fifo_full    [0:masters-1],
    input  logic                  master_write_data_fifo_empty  [0:masters-1],
    input  logic [SW-1:0]         write_data_forward_dest_slave [0:masters-1],
    input  logic [DATA_WIDTH-1:0] WDATA                         [0:masters-1],
    input  logic [STRB_WIDTH-1:0] WSTRB                         [0:masters-1],
    input  logic                  WLAST                         [0:masters-1],
    output logic                  slave_write_data_fifo_full    [0:masters-1],
    output logic                  slave_write_resp_fifo_empty,
    output logic [MW-1:0]         write_resp_return_dest_master,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    input  logic [SW-1:0]         grant_write_resp_return_slave [0:masters-1],
    input  logic                  master_write_resp_fifo_full   [0:masters-1],
    output logic [ID_WIDTH-1:0]   AWID_S,
    output logic [ADDR_WIDTH-1:0] AWADDR_S,
    output logic [LEN_WIDTH-1:0]  AWLEN_S,
    output logic [SIZE_WIDTH-1:0] AWSIZE_S,
    output logic [1:0]            AWBURST_S,
    output logic                  AWVALID_S,
    input  logic                  AWREADY_S,
    output logic [DATA_WIDTH-1:0] WDATA_S,
    output logic [STRB_WIDTH-1:0] WSTRB_S,
    output logic                  WLAST_S,
    output logic                  WVALID_S,
    input  logic                  WREADY_S,
    input  logic [ID_WIDTH-1:0]   BID_S,
    input  logic [1:0]            BRESP_S,
    input  logic                  BVALID_S,
    output logic                  BREADY_S
);
    localparam logic [SW-1:0] MY_SLAVE = SW'(i_am_slave_number);
    localparam int            NID      = 2 ** ID_WIDTH;

    wr_state_e             state_q;
    logic [MW-1:0]         rr_ptr_q;
    logic [MW-1:0]         owner_q;
    logic                  awvalid_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [LEN_WIDTH-1:0]  awlen_q;
    logic [SIZE_WIDTH-1:0] awsize_q;
    logic [1:0]            awburst_q;
    logic [NID-1:0]        id_busy_q;
    logic [MW-1:0]         id_owner_q [NID];

    logic [masters-1:0]    req;
    logic                  grant_vld;
    logic [MW-1:0]         grant_idx;
    logic [MW-1:0]         idx;
    logic                  aw_hs;
    logic                  w_hs;
    b_entry_t              b_din;
    b_entry_t              b_head;
    logic                  b_push;
    logic                  b_pop;
    logic                  b_full;
    logic                  b_empty;

    always_comb begin
        req = '0;
        for (int m = 0; m < masters; m++)
            req[m] = ~master_write_addr_fifo_empty[m]
                   & (write_addr_forward_dest_slave[m] == MY_SLAVE)
                   & ~id_busy_q[AWID[m]];
    end

    // First requester at or after rr_ptr wins; grants only happen from IDLE.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < masters; i++) begin
            idx = MW'((int'(rr_ptr_q) + i) % masters);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        if (state_q != IDLE || !ARESETn)
            grant_vld = 1'b0;
    end

    assign WVALID_S = (state_q == BUSY) & ~w_done_q
                    & ~master_write_data_fifo_empty[owner_q]
                    & (write_data_forward_dest_slave[owner_q] == MY_SLAVE);
    assign WDATA_S  = WDATA[owner_q];
    assign WSTRB_S  = WSTRB[owner_q];
    assign WLAST_S  = WLAST[owner_q];
    assign w_hs     = WVALID_S & WREADY_S;
    assign aw_hs    = awvalid_q & AWREADY_S;

    always_comb begin
        for (int m = 0; m < masters; m++) begin
            slave_write_addr_fifo_full[m] = ~(grant_vld && grant_idx == MW'(m));
            slave_write_data_fifo_full[m] = ~(w_hs && owner_q == MW'(m));
        end
    end

    assign AWVALID_S = awvalid_q;
    assign AWID_S    = awid_q;
    assign AWADDR_S  = awaddr_q;
    assign AWLEN_S   = awlen_q;
    assign AWSIZE_S  = awsize_q;
    assign AWBURST_S = awburst_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            id_busy_q <= '0;
            for (int i = 0; i < NID; i++)
                id_owner_q[i] <= '0;
        end else begin
            if (b_push)
                id_busy_q[BID_S] <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q                      <= grant_idx;
                        awid_q                       <= AWID[grant_idx];
                        awaddr_q                     <= AWADDR[grant_idx];
                        awlen_q                      <= AWLEN[grant_idx];
                        awsize_q                     <= AWSIZE[grant_idx];
                        awburst_q                    <= AWBURST[grant_idx];
                        awvalid_q                    <= 1'b1;
                        aw_done_q                    <= 1'b0;
                        w_done_q                     <= 1'b0;
                        id_busy_q[AWID[grant_idx]]  <= 1'b1;
                        id_owner_q[AWID[grant_idx]] <= grant_idx;
                        rr_ptr_q                     <= MW'((int'(grant_idx) + 1) % masters);
                        state_q                      <= BUSY;
                    end
                end
                BUSY: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs && WLAST_S)
                        w_done_q <= 1'b1;
                    if (aw_done_q && w_done_q) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BREADY_S = ~b_full;
    assign b_push   = BVALID_S & ~b_full;
    assign b_din    = '{id: BID_S, resp: BRESP_S, dest: id_owner_q[BID_S]};
    assign b_pop    = ~b_empty
                    & (grant_write_resp_return_slave[b_head.dest] == MY_SLAVE)
                    & ~master_write_resp_fifo_full[b_head.dest];

    b_ret_buf u_b_ret_buf (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push_i  (b_push),
        .din_i   (b_din),
        .pop_i   (b_pop),
        .dout_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    assign slave_write_resp_fifo_empty   = b_empty;
    assign write_resp_return_dest_master = b_head.dest;
    assign BID                           = b_head.id;
    assign BRESP                         = b_head.resp;

    // A B for an ID with nothing outstanding is a slave protocol error.
    a_bid_outstanding: assert property (@(posedge ACLK) disable iff (!ARESETn)
        b_push |-> id_busy_q[BID_S]);
endmodule

// File: tb/tb_xbar_slave_write_port.sv
// Directed bench for xbar_slave_write_port: arbitration, W locking, ID blocking, B buffer, reset.
module tb_xbar_slave_write_port;
    import xbar_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        master_write_addr_fifo_empty  [0:1];
    logic [SW-1:0] write_addr_forward_dest_slave [0:1];
    logic [3:0]  AWID    [0:1];
    logic [31:0] AWADDR  [0:1];
    logic [3:0]  AWLEN   [0:1];
    logic [2:0]  AWSIZE  [0:1];
    logic [1:0]  AWBURST [0:1];
    logic        slave_write_addr_fifo_full    [0:1];
    logic        master_write_data_fifo_empty  [0:1];
    logic [SW-1:0] write_data_forward_dest_slave [0:1];
    logic [31:0] WDATA [0:1];
    logic [3:0]  WSTRB [0:1];
    logic        WLAST [0:1];
    logic        slave_write_data_fifo_full    [0:1];
    logic        slave_write_resp_fifo_empty;
    logic [MW-1:0] write_resp_return_dest_master;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic [SW-1:0] grant_write_resp_return_slave [0:1];
    logic        master_write_resp_fifo_full   [0:1];
    logic [3:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic        AWVALID_S, AWREADY_S;
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S, WVALID_S, WREADY_S;
    logic [3:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S, BREADY_S;

    always #5 ACLK = ~ACLK;

    xbar_slave_write_port dut (
        .ACLK                          (ACLK),
        .ARESETn                       (ARESETn),
        .master_write_addr_fifo_empty  (master_write_addr_fifo_empty),
        .write_addr_forward_dest_slave (write_addr_forward_dest_slave),
        .AWID                          (AWID),
        .AWADDR                        (AWADDR),
        .AWLEN                         (AWLEN),
        .AWSIZE                        (AWSIZE),
        .AWBURST                       (AWBURST),
        .slave_write_addr_fifo_full    (slave_write_addr_fifo_full),
        .master_write_data_fifo_empty  (master_write_data_fifo_empty),
        .write_data_forward_dest_slave (write_data_forward_dest_slave),
        .WDATA                         (WDATA),
        .WSTRB                         (WSTRB),
        .WLAST                         (WLAST),
        .slave_write_data_fifo_full    (slave_write_data_fifo_full),
        .slave_write_resp_fifo_empty   (slave_write_resp_fifo_empty),
        .write_resp_return_dest_master (write_resp_return_dest_master),
        .BID                           (BID),
        .BRESP                         (BRESP),
        .grant_write_resp_return_slave (grant_write_resp_return_slave),
        .master_write_resp_fifo_full   (master_write_resp_fifo_full),
        .AWID_S                        (AWID_S),
        .AWADDR_S                      (AWADDR_S),
        .AWLEN_S                       (AWLEN_S),
        .AWSIZE_S                      (AWSIZE_S),
        .AWBURST_S                     (AWBURST_S),
        .AWVALID_S                     (AWVALID_S),
        .AWREADY_S                     (AWREADY_S),
        .WDATA_S                       (WDATA_S),
        .WSTRB_S                       (WSTRB_S),
        .WLAST_S                       (WLAST_S),
        .WVALID_S                      (WVALID_S),
        .WREADY_S                      (WREADY_S),
        .BID_S                         (BID_S),
        .BRESP_S                       (BRESP_S),
        .BVALID_S                      (BVALID_S),
        .BREADY_S                      (BREADY_S)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_set(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len);
        master_write_addr_fifo_empty[m]  = 1'b0;
        write_addr_forward_dest_slave[m] = '0;
        AWID[m]    = id;
        AWADDR[m]  = addr;
        AWLEN[m]   = len;
        AWSIZE[m]  = 3'd2;
        AWBURST[m] = 2'd1;
    endtask

    task automatic w_stream(input int m, input int nbeats);
        master_write_data_fifo_empty[m]  = 1'b0;
        write_data_forward_dest_slave[m] = '0;
        WREADY_S = 1'b1;
        for (int k = 0; k < nbeats; k++) begin
            WDATA[m] = 32'hD000_0000 + 32'(m * 256 + k);
            WSTRB[m] = 4'hF;
            WLAST[m] = (k == nbeats - 1);
            #1;
            check("w_valid", WVALID_S, 1'b1);
            check("w_data", WDATA_S, 32'hD000_0000 + 32'(m * 256 + k));
            check("w_pop", slave_write_data_fifo_full[m], 1'b0);
            check("w_other", slave_write_data_fifo_full[1-m], 1'b1);
            tick();
        end
        master_write_data_fifo_empty[m] = 1'b1;
        WLAST[m] = 1'b0;
    endtask

    task automatic pulse_reset();
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            master_write_addr_fifo_empty[m]  = 1'b1;
            write_addr_forward_dest_slave[m] = '0;
            AWID[m] = '0; AWADDR[m] = '0; AWLEN[m] = '0; AWSIZE[m] = '0; AWBURST[m] = '0;
            master_write_data_fifo_empty[m]  = 1'b1;
            write_data_forward_dest_slave[m] = '0;
            WDATA[m] = '0; WSTRB[m] = '0; WLAST[m] = 1'b0;
            grant_write_resp_return_slave[m] = 1'b1;
            master_write_resp_fifo_full[m]   = 1'b0;
        end
        AWREADY_S = 1'b0; WREADY_S = 1'b0;
        BID_S = '0; BRESP_S = '0; BVALID_S = 1'b0;

        // reset state
        tick(); tick();
        check("rst_awvalid", AWVALID_S, 1'b0);
        check("rst_wvalid", WVALID_S, 1'b0);
        check("rst_bready", BREADY_S, 1'b1);
        check("rst_bempty", slave_write_resp_fifo_empty, 1'b1);
        check("rst_afull0", slave_write_addr_fifo_full[0], 1'b1);
        check("rst_afull1", slave_write_addr_fifo_full[1], 1'b1);
        check("rst_dfull0", slave_write_data_fifo_full[0], 1'b1);
        check("rst_dfull1", slave_write_data_fifo_full[1], 1'b1);
        ARESETn = 1'b1;
        tick();

        // single burst from M0
        aw_set(0, 4'd3, 32'h1000, 4'd3);
        AWREADY_S = 1'b1;
        #1;
        check("t1_grant0", slave_write_addr_fifo_full[0], 1'b0);
        check("t1_nogrant1", slave_write_addr_fifo_full[1], 1'b1);
        tick();
        master_write_addr_fifo_empty[0] = 1'b1;
        #1;
        check("t1_awvalid", AWVALID_S, 1'b1);
        check("t1_awid", AWID_S, 4'd3);
        check("t1_awaddr", AWADDR_S, 32'h1000);
        check("t1_awlen", AWLEN_S, 4'd3);
        w_stream(0, 4);
        aw_set(1, 4'd7, 32'h2000, 4'd0);
        #1;
        check("t1_done_cycle", slave_write_addr_fifo_full[1], 1'b1);
        tick();
        check("t1_idle", slave_write_addr_fifo_full[1], 1'b0);
        check("t1_awvalid_lo", AWVALID_S, 1'b0);
        master_write_addr_fifo_empty[1] = 1'b1;
        pulse_reset();

        // round robin, including wrap of rr_ptr
        aw_set(0, 4'd1, 32'h100, 4'd0);
        aw_set(1, 4'd2, 32'h200, 4'd0);
        #1;
        check("t2_r1_m0", slave_write_addr_fifo_full[0], 1'b0);
        check("t2_r1_m1", slave_write_addr_fifo_full[1], 1'b1);
        tick();
        master_write_addr_fifo_empty[0] = 1'b1;
        check("t2_r1_awid", AWID_S, 4'd1);
        w_stream(0, 1);
        tick();
        check("t2_r2_m1", slave_write_addr_fifo_full[1], 1'b0);
        tick();
        master_write_addr_fifo_empty[1] = 1'b1;
        check("t2_r2_awid", AWID_S, 4'd2);
        w_stream(1, 1);
        tick();
        aw_set(0, 4'd4, 32'h400, 4'd0);
        aw_set(1, 4'd6, 32'h600, 4'd0);
        #1;
        check("t2_r3_m0", slave_write_addr_fifo_full[0], 1'b0);
        check("t2_r3_m1", slave_write_addr_fifo_full[1], 1'b1);
        tick();
        master_write_addr_fifo_empty[0] = 1'b1;
        w_stream(0, 1);
        tick();
        check("t2_r4_m1", slave_write_addr_fifo_full[1], 1'b0);
        tick();
        master_write_addr_fifo_empty[1] = 1'b1;
        w_stream(1, 1);
        tick();

        // same AWID from another master blocked until its B is captured
        aw_set(1, 4'd5, 32'h500, 4'd1);
        #1;
        check("t3_m1_grant", slave_write_addr_fifo_full[1], 1'b0);
        tick();
        master_write_addr_fifo_empty[1] = 1'b1;
        w_stream(1, 2);
        tick();
        aw_set(0, 4'd5, 32'h5500, 4'd0);
        #1;
        check("t3_blocked", slave_write_addr_fifo_full[0], 1'b1);
        tick(); tick(); tick();
        check("t3_still_blocked", slave_write_addr_fifo_full[0], 1'b1);
        BVALID_S = 1'b1; BID_S = 4'd5; BRESP_S = 2'd0;
        #1;
        check("t3_b_ready", BREADY_S, 1'b1);
        check("t3_same_cycle", slave_write_addr_fifo_full[0], 1'b1);
        tick();
        BVALID_S = 1'b0;
        #1;
        check("t3_grant", slave_write_addr_fifo_full[0], 1'b0);
        check("t3_bempty", slave_write_resp_fifo_empty, 1'b0);
        check("t3_bid", BID, 4'd5);
        check("t3_bdest", write_resp_return_dest_master, 1'b1);
        tick();
        master_write_addr_fifo_empty[0] = 1'b1;
        w_stream(0, 1);
        tick();

        // AWREADY held low while W streams
        AWREADY_S = 1'b0;
        aw_set(0, 4'd9, 32'h9000, 4'd1);
        #1;
        check("t4_grant", slave_write_addr_fifo_full[0], 1'b0);
        tick();
        master_write_addr_fifo_empty[0] = 1'b1;
        w_stream(0, 2);
        for (int c = 0; c < 3; c++) begin
            check("t4_awvalid_hold", AWVALID_S, 1'b1);
            check("t4_awaddr_hold", AWADDR_S, 32'h9000);
            tick();
        end
        aw_set(1, 4'd10, 32'hA000, 4'd0);
        #1;
        check("t4_busy", slave_write_addr_fifo_full[1], 1'b1);
        AWREADY_S = 1'b1;
        tick();
        check("t4_aw_acc", AWVALID_S, 1'b0);
        check("t4_done_cycle", slave_write_addr_fifo_full[1], 1'b1);
        tick();
        check("t4_idle", slave_write_addr_fifo_full[1], 1'b0);
        master_write_addr_fifo_empty[1] = 1'b1;
        #1;

        // B buffer fill, blocked pop, pop with simultaneous push at full
        BVALID_S = 1'b1; BID_S = 4'd9; BRESP_S = 2'd2;
        tick();
        BVALID_S = 1'b0;
        #1;
        check("t5_full", BREADY_S, 1'b0);
        check("t5_head_id", BID, 4'd5);
        check("t5_head_dest", write_resp_return_dest_master, 1'b1);
        grant_write_resp_return_slave[1] = 1'b0;
        BVALID_S = 1'b1; BID_S = 4'd5; BRESP_S = 2'd1;
        #1;
        check("t5_full_push", BREADY_S, 1'b0);
        tick();
        grant_write_resp_return_slave[1] = 1'b1;
        #1;
        check("t5_after_pop", BREADY_S, 1'b1);
        check("t5_head2_id", BID, 4'd9);
        check("t5_head2_resp", BRESP, 2'd2);
        check("t5_head2_dest", write_resp_return_dest_master, 1'b0);
        tick();
        BVALID_S = 1'b0;
        #1;
        check("t5_refull", BREADY_S, 1'b0);
        grant_write_resp_return_slave[0] = 1'b0;
        master_write_resp_fifo_full[0] = 1'b1;
        tick();
        check("t5_mfull", BREADY_S, 1'b0);
        master_write_resp_fifo_full[0] = 1'b0;
        tick();
        check("t5_head3_id", BID, 4'd5);
        check("t5_head3_resp", BRESP, 2'd1);
        check("t5_head3_dest", write_resp_return_dest_master, 1'b0);
        tick();
        check("t5_drained", slave_write_resp_fifo_empty, 1'b1);
        grant_write_resp_return_slave[0] = 1'b1;

        // reset in the middle of a W burst
        aw_set(1, 4'd11, 32'hB000, 4'd3);
        #1;
        tick();
        master_write_addr_fifo_empty[1] = 1'b1;
        master_write_data_fifo_empty[1] = 1'b0;
        WDATA[1] = 32'h1111_0000; WSTRB[1] = 4'hF; WLAST[1] = 1'b0;
        WREADY_S = 1'b1;
        tick();
        BVALID_S = 1'b1; BID_S = 4'd11; BRESP_S = 2'd0;
        tick();
        BVALID_S = 1'b0;
        check("t6_pre_bempty", slave_write_resp_fifo_empty, 1'b0);
        check("t6_pre_wvalid", WVALID_S, 1'b1);
        aw_set(0, 4'd12, 32'hC000, 4'd0);
        ARESETn = 1'b0;
        tick();
        check("t6_awvalid", AWVALID_S, 1'b0);
        check("t6_wvalid", WVALID_S, 1'b0);
        check("t6_bempty", slave_write_resp_fifo_empty, 1'b1);
        check("t6_bready", BREADY_S, 1'b1);
        check("t6_afull0", slave_write_addr_fifo_full[0], 1'b1);
        check("t6_afull1", slave_write_addr_fifo_full[1], 1'b1);
        check("t6_dfull0", slave_write_data_fifo_full[0], 1'b1);
        check("t6_dfull1", slave_write_data_fifo_full[1], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
